// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}; DIV_ZERO_FAST_EN shortcuts zero divisors.
// Latency: ready high 33 edges after accept; ready is a level held until start drops or annul arrives.
module div_radix2 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 start,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   quo, quo_nxt;
   logic [WIDTH:0]     rem, rem_nxt;
   logic [WIDTH:0]     dvs, dvs_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               qsign, qsign_nxt;
   logic               rsign, rsign_nxt;
   logic               dz, dz_nxt;
   logic [2*WIDTH-1:0] result_nxt;

   logic               sign1, sign2;
   logic [WIDTH:0]     op2_ext;
   logic [WIDTH+1:0]   rem_sh, diff;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               last_step;
   logic               fix_hold;

   assign sign1 = signed_div & opdata1[WIDTH-1];
   assign sign2 = signed_div & opdata2[WIDTH-1];

   // Divisor magnitude is taken one bit wider so |most-negative| stays positive.
   assign op2_ext = {sign2, opdata2};

   assign rem_sh    = {rem, quo[WIDTH-1]};
   assign diff      = rem_sh - {1'b0, dvs};
   assign quo_fix   = qsign ? -quo : quo;
   assign rem_fix   = rsign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
   // Zero divisor enters FIX with cnt=0 and dwells one edge there, so ready lands at E+2.
   assign fix_hold = dz && (cnt == '0);
`else
   assign fix_hold = 1'b0;
`endif

   assign ready = (state == DONE);

   always_comb begin
      state_nxt  = state;
      quo_nxt    = quo;
      rem_nxt    = rem;
      dvs_nxt    = dvs;
      cnt_nxt    = cnt;
      qsign_nxt  = qsign;
      rsign_nxt  = rsign;
      dz_nxt     = dz;
      result_nxt = result;

      case (state)
         IDLE: begin
            if (start && !annul) begin
               dz_nxt    = (opdata2 == '0);
               quo_nxt   = (opdata2 == '0) ? '0 : (sign1 ? -opdata1 : opdata1);
               rem_nxt   = '0;
               dvs_nxt   = sign2 ? -op2_ext : op2_ext;
               qsign_nxt = sign1 ^ sign2;
               rsign_nxt = sign1;
               cnt_nxt   = '0;
`ifdef DIV_ZERO_FAST_EN
               state_nxt = (opdata2 == '0) ? FIX : BUSY;
`else
               state_nxt = BUSY;
`endif
            end
         end

         BUSY: begin
            if (annul) begin
               state_nxt = IDLE;
            end else begin
               if (dz) begin
                  // Zero divisor still walks all steps but keeps the datapath at zero.
                  quo_nxt = '0;
                  rem_nxt = '0;
               end else if (!diff[WIDTH+1]) begin
                  rem_nxt = diff[WIDTH:0];
                  quo_nxt = {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem_nxt = rem_sh[WIDTH:0];
                  quo_nxt = {quo[WIDTH-2:0], 1'b0};
               end
               cnt_nxt = cnt + CNT_W'(1);
               if (last_step) begin
                  state_nxt = FIX;
               end
            end
         end

         FIX: begin
            if (annul) begin
               state_nxt = IDLE;
            end else if (fix_hold) begin
               cnt_nxt = CNT_W'(1);
            end else begin
               result_nxt = {rem_fix, quo_fix};
               state_nxt  = DONE;
            end
         end

         DONE: begin
            if (annul || !start) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         qsign  <= 1'b0;
         rsign  <= 1'b0;
         dz     <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         quo    <= quo_nxt;
         rem    <= rem_nxt;
         dvs    <= dvs_nxt;
         cnt    <= cnt_nxt;
         qsign  <= qsign_nxt;
         rsign  <= rsign_nxt;
         dz     <= dz_nxt;
         result <= result_nxt;
      end
   end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: scoreboard of expected {rem, quo} checked at ready.
module tb_div_radix2;
   localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 33;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           signed_div;
   logic [W-1:0]   opdata1;
   logic [W-1:0]   opdata2;
   logic           start;
   logic           annul;
   logic [2*W-1:0] result;
   logic           ready;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb[$];
   logic [63:0] last_res;

   always #5 clk = ~clk;

   div_radix2 #(.WIDTH(W), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .start      (start),
      .annul      (annul),
      .result     (result),
      .ready      (ready)
   );

   function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      if (b == 32'h0) return 64'h0;
      if (sd) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
      end else begin
         sa  = longint'({32'h0, a});
         sbv = longint'({32'h0, b});
      end
      q = sa / sbv;
      r = sa % sbv;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      signed_div = sd;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      sb.push_back(exp);
   endtask

   // lat = index of the edge after which ready was first seen (accept edge = 0), -1 on timeout.
   task automatic wait_ready(output int lat);
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (k == 0) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = ~signed_div;
         end
         if (ready) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      opdata1 = '0; opdata2 = '0;
      repeat (3) step();
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_tests++;
      if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      rst = 1'b0;
      step();
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready: got %b want 0", ready); end
      last_res = 64'h0;
   endtask

   task automatic test_table(input string name, input logic sd[], input logic [31:0] a[],
                             input logic [31:0] b[], input logic [63:0] e[], input int exp_lat);
      int lat;
      logic [63:0] exp;
      for (int i = 0; i < a.size(); i++) begin
         issue(sd[i], a[i], b[i], e[i]);
         wait_ready(lat);
         exp = sb.pop_front();
         n_tests++;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_lat[%0d]: got %0d want %0d", name, i, lat, exp_lat); end
         n_tests++;
         if (result !== exp) begin n_fail++; $display("FAIL %s_res[%0d]: got %h want %h", name, i, result, exp); end
         start = 1'b0;
         step();
         n_tests++;
         if (ready !== 1'b0) begin n_fail++; $display("FAIL %s_drop[%0d]: got %b want 0", name, i, ready); end
         last_res = exp;
      end
   endtask

   task automatic test_unsigned();
      test_table("unsigned", '{1'b0, 1'b0}, '{32'd100, 32'hFFFFFFFF}, '{32'd7, 32'd1},
                 '{64'h00000002_0000000E, 64'h00000000_FFFFFFFF}, 33);
   endtask

   task automatic test_signed();
      test_table("signed", '{1'b1, 1'b1, 1'b1},
                 '{32'hFFFFFFF9, 32'h00000007, 32'h80000000},
                 '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF},
                 '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000}, 33);
   endtask

   task automatic test_random();
      logic        sd[6];
      logic [31:0] a[6], b[6];
      logic [63:0] e[6];
      for (int i = 0; i < 6; i++) begin
         sd[i] = 1'($urandom_range(0, 1));
         a[i]  = $urandom;
         b[i]  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b[i] == 32'h0) b[i] = 32'd3;
         e[i]  = model(sd[i], a[i], b[i]);
      end
      test_table("random", sd, a, b, e, 33);
   endtask

   task automatic test_div_zero();
      test_table("divzero", '{1'b0, 1'b1}, '{32'h12345678, 32'h87654321}, '{32'h0, 32'h0},
                 '{64'h0, 64'h0}, ZERO_LAT);
   endtask

   task automatic test_annul();
      int lat;
      logic [63:0] exp;
      issue(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D);
      repeat (10) step();
      annul = 1'b1; start = 1'b0;
      step();
      annul = 1'b0;
      void'(sb.pop_back());
      for (int k = 0; k < 40; k++) begin
         step();
         n_tests++;
         if (ready !== 1'b0 || result !== last_res) begin
            n_fail++;
            $display("FAIL annul_idle[%0d]: ready %b result %h want ready 0 result %h", k, ready, result, last_res);
         end
      end
      issue(1'b0, 32'd9, 32'd4, 64'h00000001_00000002);
      wait_ready(lat);
      exp = sb.pop_front();
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL annul_next_lat: got %0d want 33", lat); end
      n_tests++;
      if (result !== exp) begin n_fail++; $display("FAIL annul_next_res: got %h want %h", result, exp); end
      start = 1'b0;
      step();
      last_res = exp;
   endtask

   task automatic test_hold_start();
      int lat;
      logic [63:0] exp;
      issue(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);
      wait_ready(lat);
      exp = sb.pop_front();
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL hold_lat: got %0d want 33", lat); end
      for (int k = 0; k < 5; k++) begin
         step();
         n_tests++;
         if (ready !== 1'b1 || result !== exp) begin
            n_fail++;
            $display("FAIL hold[%0d]: ready %b result %h want ready 1 result %h", k, ready, result, exp);
         end
      end
      start = 1'b0;
      step();
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b want 0", ready); end
      last_res = exp;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [63:0] exp;
      issue(1'b1, 32'hFFFFF000, 32'd7, model(1'b1, 32'hFFFFF000, 32'd7));
      repeat (20) step();
      rst = 1'b1; start = 1'b0;
      step();
      rst = 1'b0;
      void'(sb.pop_back());
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", ready); end
      n_tests++;
      if (result !== 64'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
      repeat (40) step();
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got %b want 0", ready); end
      issue(1'b1, 32'hFFFFFF9C, 32'd10, 64'h00000000_FFFFFFF6);
      wait_ready(lat);
      exp = sb.pop_front();
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL rst_next_lat: got %0d want 33", lat); end
      n_tests++;
      if (result !== exp) begin n_fail++; $display("FAIL rst_next_res: got %h want %h", result, exp); end
      start = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_random();
      test_div_zero();
      test_annul();
      test_hold_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
